// File: rtl/rtc_bcd_clock.sv
// ---------------------------------------------------------------------------
// rtc_bcd_clock -- single-clock real-time clock with BCD display outputs.
//
// A 1 Hz timebase is generated as a one-cycle enable (tick_1Hz) from the
// system clock. Internal time is kept in binary (sec, min, hour) and
// converted combinationally to BCD for the display drivers, in 12-hour or
// 24-hour form. Two debounced buttons with auto-repeat adjust minutes and
// hours, and a minute-resolution alarm flags a match.
//
// Ports:
//   clk_100MHz          system clock
//   reset               asynchronous, active-high reset
//   btn_hr, btn_min     raw adjust buttons (asynchronous to clk_100MHz)
//   mode_24h            1 = 24-hour display, 0 = 12-hour display with pm
//   alarm_en            alarm enable
//   alarm_hr[4:0]       alarm hour, binary 0..23
//   alarm_min[5:0]      alarm minute, binary 0..59
//   tick_1Hz            one-cycle pulse every CLK_HZ cycles
//   sq_1Hz              50% duty 1 Hz square wave
//   sec_1s..hr_10s      BCD time digits (hours in the selected mode)
//   pm                  1 when hour >= 12 in 12-hour mode
//   alarm               alarm active
// ---------------------------------------------------------------------------

// Button conditioner: synchroniser, debounce, press pulse and auto-repeat.
//   clk, reset   clock and asynchronous active-high reset
//   raw          raw button level
//   pulse        one-cycle adjust request
module rtc_bcd_btn #(
    parameter int DB_CYCLES     = 2_000_000,
    parameter int REPEAT_CYCLES = 25_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic pulse
);
    localparam int DW = $clog2(DB_CYCLES + 1);
    localparam int RW = $clog2(REPEAT_CYCLES);
    localparam logic [DW-1:0] DB_LAST  = DW'(DB_CYCLES - 1);
    localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_CYCLES - 1);

    logic          sync1;
    logic          sync2;
    logic          level;
    logic [DW-1:0] db_cnt;
    logic [RW-1:0] rep_cnt;
    logic          accept;

    // The new level is taken on the last of DB_CYCLES consecutive differing cycles.
    assign accept = (sync2 != level) && (db_cnt == DB_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1   <= 1'b0;
            sync2   <= 1'b0;
            level   <= 1'b0;
            db_cnt  <= '0;
            rep_cnt <= '0;
            pulse   <= 1'b0;
        end else begin
            // NOTE: non-blocking, so every register here samples pre-edge values
            // and the two synchroniser stages really are two flops.
            sync1 <= raw;
            sync2 <= sync1;

            if (sync2 == level || accept)
                db_cnt <= '0;
            else
                db_cnt <= db_cnt + 1'b1;

            if (accept)
                level <= sync2;

            pulse <= 1'b0;
            if (accept && sync2) begin
                // Fresh press: one pulse now, repeat interval restarts.
                pulse   <= 1'b1;
                rep_cnt <= '0;
            end else if (level && !accept) begin
                if (rep_cnt == REP_LAST) begin
                    pulse   <= 1'b1;
                    rep_cnt <= '0;
                end else begin
                    rep_cnt <= rep_cnt + 1'b1;
                end
            end else begin
                rep_cnt <= '0;
            end
        end
    end
endmodule

module rtc_bcd_clock #(
    parameter int CLK_HZ        = 100_000_000,
    parameter int DB_CYCLES     = 2_000_000,
    parameter int REPEAT_CYCLES = 25_000_000
) (
    input  logic       clk_100MHz,
    input  logic       reset,
    input  logic       btn_hr,
    input  logic       btn_min,
    input  logic       mode_24h,
    input  logic       alarm_en,
    input  logic [4:0] alarm_hr,
    input  logic [5:0] alarm_min,
    output logic       tick_1Hz,
    output logic       sq_1Hz,
    output logic [3:0] sec_1s,
    output logic [3:0] sec_10s,
    output logic [3:0] min_1s,
    output logic [3:0] min_10s,
    output logic [3:0] hr_1s,
    output logic [3:0] hr_10s,
    output logic       pm,
    output logic       alarm
);
    localparam int TW = $clog2(CLK_HZ);
    localparam logic [TW-1:0] TICK_LAST = TW'(CLK_HZ - 1);
    localparam logic [TW-1:0] TICK_HALF = TW'(CLK_HZ / 2);

    logic [TW-1:0] tick_ctr;
    logic [5:0]    sec, min, sec_n, min_n;
    logic [4:0]    hour, hour_n, hr_disp;
    logic          hr_pulse, min_pulse;
    logic          update, alarm_hit, alarm_q;

    function automatic logic [7:0] to_bcd(input logic [5:0] v);
        return {4'(v / 6'd10), 4'(v % 6'd10)};
    endfunction

    rtc_bcd_btn #(.DB_CYCLES(DB_CYCLES), .REPEAT_CYCLES(REPEAT_CYCLES)) u_btn_hr (
        .clk(clk_100MHz), .reset(reset), .raw(btn_hr), .pulse(hr_pulse)
    );

    rtc_bcd_btn #(.DB_CYCLES(DB_CYCLES), .REPEAT_CYCLES(REPEAT_CYCLES)) u_btn_min (
        .clk(clk_100MHz), .reset(reset), .raw(btn_min), .pulse(min_pulse)
    );

    // Timebase
    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset)
            tick_ctr <= '0;
        else if (tick_1Hz)
            tick_ctr <= '0;
        else
            tick_ctr <= tick_ctr + 1'b1;
    end

    assign tick_1Hz = (tick_ctr == TICK_LAST);
    // The counter rests at 0 during reset; gate so the wave is low until released.
    assign sq_1Hz   = !reset && (tick_ctr < TICK_HALF);

    // Next time: tick first, then adjust pulses override their fields.
    always_comb begin
        // NOTE: every output gets a default first so no branch can leave a latch.
        sec_n  = sec;
        min_n  = min;
        hour_n = hour;
        if (tick_1Hz) begin
            if (sec == 6'd59) begin
                sec_n = 6'd0;
                if (min == 6'd59) begin
                    min_n  = 6'd0;
                    hour_n = (hour == 5'd23) ? 5'd0 : hour + 5'd1;
                end else begin
                    min_n = min + 6'd1;
                end
            end else begin
                sec_n = sec + 6'd1;
            end
        end
        if (min_pulse) begin
            // Minute set restarts the minute and never carries into the hour.
            sec_n  = 6'd0;
            min_n  = (min == 6'd59) ? 6'd0 : min + 6'd1;
            hour_n = hour;
        end
        if (hr_pulse)
            hour_n = (hour == 5'd23) ? 5'd0 : hour + 5'd1;
    end

    assign update    = tick_1Hz || min_pulse || hr_pulse;
    assign alarm_hit = update && alarm_en && (hour_n == alarm_hr)
                       && (min_n == alarm_min) && (sec_n == 6'd0);

    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            sec     <= 6'd0;
            min     <= 6'd0;
            hour    <= 5'd0;
            alarm_q <= 1'b0;
        end else begin
            sec     <= sec_n;
            min     <= min_n;
            hour    <= hour_n;
            alarm_q <= alarm_hit || (alarm_q && alarm_en && (min_n == alarm_min));
        end
    end

    // Gate so dropping alarm_en or leaving the minute silences it immediately.
    assign alarm = alarm_q && alarm_en && (min == alarm_min);

    // Display conversion
    always_comb begin
        hr_disp = hour;
        if (!mode_24h) begin
            if (hour == 5'd0)
                hr_disp = 5'd12;
            else if (hour > 5'd12)
                hr_disp = hour - 5'd12;
        end
    end

    assign pm = !mode_24h && (hour >= 5'd12);
    assign {sec_10s, sec_1s} = to_bcd(sec);
    assign {min_10s, min_1s} = to_bcd(min);
    assign {hr_10s, hr_1s}   = to_bcd({1'b0, hr_disp});
endmodule

// File: tb/tb_rtc_bcd_clock.sv
// ---------------------------------------------------------------------------
// tb_rtc_bcd_clock -- directed self-checking bench for rtc_bcd_clock with
// CLK_HZ=10, DB_CYCLES=3, REPEAT_CYCLES=20. Time values are compared as
// packed BCD (hh mm ss) so expected values read directly as clock times.
// ---------------------------------------------------------------------------
module tb_rtc_bcd_clock;
    logic       clk_100MHz = 1'b0;
    logic       reset      = 1'b1;
    logic       btn_hr     = 1'b0;
    logic       btn_min    = 1'b0;
    logic       mode_24h   = 1'b0;
    logic       alarm_en   = 1'b0;
    logic [4:0] alarm_hr   = 5'd7;
    logic [5:0] alarm_min  = 6'd30;
    logic       tick_1Hz, sq_1Hz, pm, alarm;
    logic [3:0] sec_1s, sec_10s, min_1s, min_10s, hr_1s, hr_10s;

    int n_vec  = 0;
    int n_miss = 0;

    rtc_bcd_clock #(.CLK_HZ(10), .DB_CYCLES(3), .REPEAT_CYCLES(20)) dut (
        .clk_100MHz(clk_100MHz), .reset(reset),
        .btn_hr(btn_hr), .btn_min(btn_min),
        .mode_24h(mode_24h), .alarm_en(alarm_en),
        .alarm_hr(alarm_hr), .alarm_min(alarm_min),
        .tick_1Hz(tick_1Hz), .sq_1Hz(sq_1Hz),
        .sec_1s(sec_1s), .sec_10s(sec_10s),
        .min_1s(min_1s), .min_10s(min_10s),
        .hr_1s(hr_1s), .hr_10s(hr_10s),
        .pm(pm), .alarm(alarm)
    );

    always #5 clk_100MHz = ~clk_100MHz;

    function automatic logic [23:0] disp();
        return {hr_10s, hr_1s, min_10s, min_1s, sec_10s, sec_1s};
    endfunction

    function automatic logic [7:0] hr_bcd();
        return {hr_10s, hr_1s};
    endfunction

    function automatic logic [7:0] min_bcd();
        return {min_10s, min_1s};
    endfunction

    function automatic logic [7:0] sec_bcd();
        return {sec_10s, sec_1s};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk_100MHz);
    endtask

    // Hold a button until its field reaches target, release, and confirm it stays.
    task automatic hold_until(input bit use_hr, input logic [7:0] target, input string tag);
        logic [7:0] cur;
        cur = use_hr ? hr_bcd() : min_bcd();
        if (use_hr) btn_hr = 1'b1; else btn_min = 1'b1;
        for (int n = 0; n < 1300; n++) begin
            @(negedge clk_100MHz);
            cur = use_hr ? hr_bcd() : min_bcd();
            if (cur == target) break;
        end
        check({tag, "_reach"}, cur, target);
        btn_hr  = 1'b0;
        btn_min = 1'b0;
        step(12);
        cur = use_hr ? hr_bcd() : min_bcd();
        check({tag, "_settle"}, cur, target);
    endtask

    task automatic wait_sec(input logic [7:0] target);
        for (int n = 0; n < 620; n++) begin
            @(negedge clk_100MHz);
            if (sec_bcd() == target) break;
        end
        check("wait_sec", sec_bcd(), target);
    endtask

    task automatic wait_tick();
        for (int n = 0; n < 12; n++) begin
            @(negedge clk_100MHz);
            if (tick_1Hz) break;
        end
        check("wait_tick", tick_1Hz, 1);
    endtask

    initial begin
        #600_000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state
        step(3);
        check("rst_disp_12h", disp(), 24'h120000);
        check("rst_pm", pm, 0);
        check("rst_tick", tick_1Hz, 0);
        check("rst_sq", sq_1Hz, 0);
        check("rst_alarm", alarm, 0);
        mode_24h = 1'b1;
        #1;
        check("rst_disp_24h", disp(), 24'h000000);
        mode_24h = 1'b0;

        // Timebase: cycle k counted from reset release
        @(negedge clk_100MHz);
        reset = 1'b0;
        #1;
        for (int k = 0; k < 30; k++) begin
            check($sformatf("tick_c%0d", k), tick_1Hz, (k % 10 == 9));
            check($sformatf("sq_c%0d", k), sq_1Hz, (k % 10 < 5));
            @(negedge clk_100MHz);
            #1;
        end
        check("three_ticks", disp(), 24'h120003);
        check("three_ticks_pm", pm, 0);

        // Debounce: 2-cycle glitches are rejected
        for (int g = 0; g < 3; g++) begin
            btn_min = 1'b1;
            step(2);
            btn_min = 1'b0;
            step(4);
        end
        step(6);
        check("glitch_min", min_bcd(), 8'h00);
        check("glitch_hr", hr_bcd(), 8'h12);

        // Single press: one increment, seconds cleared
        btn_min = 1'b1;
        for (int n = 0; n < 12; n++) begin
            @(negedge clk_100MHz);
            if (min_bcd() != 8'h00) break;
        end
        check("press_min", min_bcd(), 8'h01);
        check("press_sec0", sec_bcd(), 8'h00);
        step(4);
        btn_min = 1'b0;
        step(12);
        check("press_once", min_bcd(), 8'h01);

        // Auto-repeat: 57 -> 58 -> 59 -> 00 -> 01, hour untouched
        hold_until(1'b0, 8'h57, "min57");
        btn_min = 1'b1;
        step(70);
        btn_min = 1'b0;
        step(12);
        check("repeat_min", min_bcd(), 8'h01);
        check("repeat_hr", hr_bcd(), 8'h12);

        // Day wrap in 24h mode, and immediate mode switching
        mode_24h = 1'b1;
        hold_until(1'b1, 8'h23, "hr23");
        hold_until(1'b0, 8'h59, "min59a");
        wait_sec(8'h59);
        check("pre_wrap", disp(), 24'h235959);
        mode_24h = 1'b0;
        #1;
        check("mode12_disp", disp(), 24'h115959);
        check("mode12_pm", pm, 1);
        mode_24h = 1'b1;
        #1;
        check("mode24_disp", disp(), 24'h235959);
        check("mode24_pm", pm, 0);
        wait_tick();
        step(1);
        check("wrap_24h", disp(), 24'h000000);

        // Noon rollover in 12h mode
        hold_until(1'b1, 8'h11, "hr11");
        hold_until(1'b0, 8'h59, "min59b");
        wait_sec(8'h59);
        mode_24h = 1'b0;
        #1;
        check("pre_noon", disp(), 24'h115959);
        check("pre_noon_pm", pm, 0);
        wait_tick();
        step(1);
        check("noon", disp(), 24'h120000);
        check("noon_pm", pm, 1);

        // Hour adjust coincident with the tick at 10:59:59
        mode_24h = 1'b1;
        hold_until(1'b1, 8'h10, "hr10a");
        hold_until(1'b0, 8'h59, "min59c");
        wait_sec(8'h58);
        wait_tick();
        step(5);
        check("pre_hr_adj", disp(), 24'h105959);
        btn_hr = 1'b1;
        wait_tick();
        step(1);
        check("hr_adj_tick", disp(), 24'h110000);
        btn_hr = 1'b0;
        step(12);
        check("hr_adj_once", hr_bcd(), 8'h11);

        // Minute adjust coincident with the tick at 10:59:59
        hold_until(1'b1, 8'h10, "hr10b");
        hold_until(1'b0, 8'h59, "min59d");
        wait_sec(8'h58);
        wait_tick();
        step(5);
        btn_min = 1'b1;
        wait_tick();
        step(1);
        check("min_adj_tick", disp(), 24'h100000);
        btn_min = 1'b0;
        step(12);
        check("min_adj_min", min_bcd(), 8'h00);
        check("min_adj_hr", hr_bcd(), 8'h10);

        // Alarm at 07:30
        alarm_en = 1'b1;
        hold_until(1'b1, 8'h07, "hr07");
        hold_until(1'b0, 8'h29, "min29");
        check("alarm_before", alarm, 0);
        wait_sec(8'h59);
        check("alarm_0729_59", alarm, 0);
        wait_tick();
        step(1);
        check("alarm_time", disp(), 24'h073000);
        check("alarm_set", alarm, 1);
        wait_sec(8'h59);
        check("alarm_hold", alarm, 1);
        wait_tick();
        step(1);
        check("alarm_0731", disp(), 24'h073100);
        check("alarm_clear", alarm, 0);
        hold_until(1'b0, 8'h30, "min30");
        check("alarm_by_adj", alarm, 1);
        alarm_en = 1'b0;
        #1;
        check("alarm_en_drop", alarm, 0);
        step(2);
        alarm_en = 1'b1;
        #1;
        check("alarm_stays_clear", alarm, 0);

        // Reset during auto-repeat with the button held
        mode_24h = 1'b0;
        btn_min  = 1'b1;
        step(40);
        reset = 1'b1;
        #1;
        check("mid_rst_disp", disp(), 24'h120000);
        check("mid_rst_pm", pm, 0);
        check("mid_rst_tick", tick_1Hz, 0);
        check("mid_rst_sq", sq_1Hz, 0);
        check("mid_rst_alarm", alarm, 0);
        step(3);
        reset = 1'b0;
        step(5);
        check("post_rst_wait", min_bcd(), 8'h00);
        step(1);
        check("post_rst_press", min_bcd(), 8'h01);
        btn_min = 1'b0;
        step(14);
        check("post_rst_once", min_bcd(), 8'h01);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
